// File: rtl/bcd_step_counter.sv
// rtl/bcd_step_counter.sv - debounced pushbutton driving a two-digit BCD up/down counter with switch load
// Optional auto-repeat while the button is held: define AUTOREPEAT_EN.
module bcd_step_counter #(
   parameter int unsigned DEB_CYCLES = 500000,
   parameter int unsigned RPT_DELAY  = 25000000,
   parameter int unsigned RPT_PERIOD = 10000000
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic       step_n,
   input  logic       up,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       wrap
);

   localparam int unsigned DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

   if (DEB_CYCLES < 2 || RPT_DELAY == 0 || RPT_PERIOD == 0) begin : g_param_check
      $error("bcd_step_counter: DEB_CYCLES must be >= 2 and repeat timings non-zero");
   end

   logic          s1;
   logic          s2;
   logic          deb;
   logic          deb_d;
   logic          pulse;
   logic          rpt_hit;
   logic [DW-1:0] deb_cnt;

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= step_n;
         s2 <= s1;
      end
   end

   // deb only follows s2 after DEB_CYCLES consecutive disagreeing samples
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         deb     <= 1'b1;
         deb_d   <= 1'b1;
         deb_cnt <= '0;
         pulse   <= 1'b0;
      end else begin
         deb_d <= deb;
         pulse <= (deb_d & ~deb) | rpt_hit;
         if (s2 == deb) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            deb     <= s2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

`ifdef AUTOREPEAT_EN
   localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int unsigned TW      = $clog2(RPT_MAX + 1);

   logic [TW-1:0] rpt_timer;
   logic          rpt_armed;

   // first repeat after RPT_DELAY held cycles, then every RPT_PERIOD
   always_comb begin
      rpt_hit = 1'b0;
      if (!deb && !load) begin
         rpt_hit = rpt_armed ? (rpt_timer == TW'(RPT_PERIOD)) : (rpt_timer == TW'(RPT_DELAY));
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         rpt_timer <= '0;
         rpt_armed <= 1'b0;
      end else if (deb || load) begin
         rpt_timer <= '0;
         rpt_armed <= 1'b0;
      end else if (rpt_hit) begin
         rpt_timer <= TW'(1);
         rpt_armed <= 1'b1;
      end else begin
         rpt_timer <= rpt_timer + 1'b1;
      end
   end
`else
   assign rpt_hit = 1'b0;
`endif

   function automatic logic [3:0] clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         tens <= 4'd0;
         ones <= 4'd0;
         wrap <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (load) begin
            tens <= clamp9(load_val[7:4]);
            ones <= clamp9(load_val[3:0]);
         end else if (pulse) begin
            if (up) begin
               if (ones != 4'd9) begin
                  ones <= ones + 4'd1;
               end else begin
                  ones <= 4'd0;
                  if (tens != 4'd9) begin
                     tens <= tens + 4'd1;
                  end else begin
                     tens <= 4'd0;
                     wrap <= 1'b1;
                  end
               end
            end else begin
               if (ones != 4'd0) begin
                  ones <= ones - 4'd1;
               end else begin
                  ones <= 4'd9;
                  if (tens != 4'd0) begin
                     tens <= tens - 4'd1;
                  end else begin
                     tens <= 4'd9;
                     wrap <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_step_counter.sv
// tb/tb_bcd_step_counter.sv - randomized self-checking bench for bcd_step_counter
// Honours AUTOREPEAT_EN the same way as the design.
module tb_bcd_step_counter;

   localparam int DEB = 4;
   localparam int RD  = 20;
   localparam int RP  = 8;
`ifdef AUTOREPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       step_n   = 1'b1;
   logic       up       = 1'b1;
   logic       load     = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       wrap;

   int vectors = 0;
   int errors  = 0;

   bcd_step_counter #(
      .DEB_CYCLES(DEB),
      .RPT_DELAY (RD),
      .RPT_PERIOD(RP)
   ) dut (
      .CLOCK_50(clk),
      .RESET   (rst),
      .step_n  (step_n),
      .up      (up),
      .load    (load),
      .load_val(load_val),
      .tens    (tens),
      .ones    (ones),
      .wrap    (wrap)
   );

   always #5 clk = ~clk;

   // behavioural model: counter value as a plain integer 0..99
   logic samp[$];
   logic s2w[$];
   logic m_deb;
   logic m_deb_prev;
   logic m_pulse;
   logic m_wrap;
   int   m_run;
   int   m_cnt;

   function automatic int clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 9 : int'(d);
   endfunction

   function automatic logic [8:0] exp_word();
      return {4'(m_cnt / 10), 4'(m_cnt % 10), m_wrap};
   endfunction

   task automatic model_reset();
      samp.delete();
      s2w.delete();
      m_deb      = 1'b1;
      m_deb_prev = 1'b1;
      m_pulse    = 1'b0;
      m_wrap     = 1'b0;
      m_run      = 0;
      m_cnt      = 0;
   endtask

   task automatic tick();
      logic       sn;
      logic       u;
      logic       ld;
      logic [7:0] lv;
      logic       s2;
      logic       all_diff;
      logic       pulse_now;
      @(posedge clk);
      sn = step_n;
      u  = up;
      ld = load;
      lv = load_val;
      s2 = (samp.size() >= 2) ? samp[samp.size() - 2] : 1'b1;
      samp.push_back(sn);
      s2w.push_back(s2);
      if (s2w.size() > DEB) void'(s2w.pop_front());
      all_diff = (s2w.size() == DEB);
      foreach (s2w[k]) if (s2w[k] == m_deb) all_diff = 1'b0;
      if (!m_deb && !ld) m_run++;
      else m_run = 0;
      pulse_now = (!m_deb && m_deb_prev) ||
                  (AUTO && (m_run == RD + 1 || (m_run > RD + 1 && (m_run - RD - 1) % RP == 0)));
      m_wrap = 1'b0;
      if (ld) begin
         m_cnt = clamp9(lv[7:4]) * 10 + clamp9(lv[3:0]);
      end else if (m_pulse) begin
         if (u) begin
            m_wrap = (m_cnt == 99);
            m_cnt  = (m_cnt + 1) % 100;
         end else begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + 99) % 100;
         end
      end
      m_pulse    = pulse_now;
      m_deb_prev = m_deb;
      if (all_diff) m_deb = ~m_deb;
      if (samp.size() > 16) void'(samp.pop_front());
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset(3);
      vectors++;
      if ({tens, ones, wrap} !== 9'h000) begin
         errors++;
         $display("FAIL reset: got tens=%h ones=%h wrap=%b, want 0/0/0", tens, ones, wrap);
      end
   endtask

   task automatic test_clean_press();
      up     = 1'b1;
      step_n = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 17) step_n = 1'b1;
         tick();
         vectors++;
         if ({tens, ones, wrap} !== exp_word()) begin
            errors++;
            $display("FAIL clean_press edge %0d: got %h%h wrap %b, want %h", i, tens, ones, wrap, exp_word());
         end
         if (i == 7 || i == 8) begin
            vectors++;
            if ({tens, ones, wrap} !== ((i == 7) ? 9'h000 : 9'h002)) begin
               errors++;
               $display("FAIL clean_press_latency edge %0d: got %h%h wrap %b", i, tens, ones, wrap);
            end
         end
      end
      vectors++;
      if ({tens, ones, wrap} !== 9'h002) begin
         errors++;
         $display("FAIL clean_press_final: got %h%h wrap %b, want 01 wrap 0", tens, ones, wrap);
      end
   endtask

   task automatic test_bounce();
      up = 1'b1;
      for (int i = 1; i <= 45; i++) begin
         if (i <= 12) step_n = ((i - 1) % 4) >= 2;
         else step_n = (i > 30);
         tick();
         vectors++;
         if ({tens, ones, wrap} !== exp_word()) begin
            errors++;
            $display("FAIL bounce edge %0d: got %h%h wrap %b, want %h", i, tens, ones, wrap, exp_word());
         end
         if (i == 19 || i == 20) begin
            vectors++;
            if ({tens, ones} !== ((i == 19) ? 8'h01 : 8'h02)) begin
               errors++;
               $display("FAIL bounce_latency edge %0d: got %h%h", i, tens, ones);
            end
         end
      end
      vectors++;
      if ({tens, ones} !== 8'h02) begin
         errors++;
         $display("FAIL bounce_single: got %h%h, want 02", tens, ones);
      end
   endtask

   task automatic test_rollover();
      int wraps;
      load_val = 8'h99;
      load     = 1'b1;
      tick();
      load = 1'b0;
      tick();
      for (int dir = 1; dir >= 0; dir--) begin
         up    = dir[0];
         wraps = 0;
         for (int i = 1; i <= 26; i++) begin
            step_n = (i > 12);
            tick();
            if (wrap === 1'b1) wraps++;
            vectors++;
            if ({tens, ones, wrap} !== exp_word()) begin
               errors++;
               $display("FAIL rollover up=%0d edge %0d: got %h%h wrap %b, want %h", dir, i, tens, ones, wrap, exp_word());
            end
         end
         vectors++;
         if (wraps != 1 || {tens, ones} !== ((dir == 1) ? 8'h00 : 8'h99)) begin
            errors++;
            $display("FAIL rollover_result up=%0d: got %h%h with %0d wrap pulses, want one wrap", dir, tens, ones, wraps);
         end
      end
   endtask

   task automatic test_load_clamp();
      int wraps = 0;
      up       = 1'b1;
      load_val = 8'h42;
      load     = 1'b1;
      tick();
      load_val = 8'hAF;
      for (int i = 1; i <= 30; i++) begin
         step_n = (i > 10);
         load   = (i <= 22);
         tick();
         if (wrap === 1'b1) wraps++;
         vectors++;
         if ({tens, ones, wrap} !== exp_word()) begin
            errors++;
            $display("FAIL load_clamp edge %0d: got %h%h wrap %b, want %h", i, tens, ones, wrap, exp_word());
         end
      end
      vectors++;
      if ({tens, ones} !== 8'h99 || wraps != 0) begin
         errors++;
         $display("FAIL load_clamp_result: got %h%h with %0d wrap pulses, want 99 and none", tens, ones, wraps);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(2);
      step_n = 1'b0;
      tick();
      tick();
      do_reset(2);
      step_n = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         vectors++;
         if ({tens, ones, wrap} !== 9'h000) begin
            errors++;
            $display("FAIL reset_mid_discard edge %0d: got %h%h wrap %b, want 00", i, tens, ones, wrap);
         end
      end
      up = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         step_n = (i > 12);
         tick();
         vectors++;
         if ({tens, ones, wrap} !== exp_word() || (i == 7 && ones !== 4'd0) || (i == 8 && ones !== 4'd1)) begin
            errors++;
            $display("FAIL reset_mid_press edge %0d: got %h%h wrap %b, want %h", i, tens, ones, wrap, exp_word());
         end
      end
   endtask

   task automatic test_autorepeat();
      int         changes    = 0;
      int         first_edge = 0;
      logic [7:0] prev;
      load_val = 8'h05;
      load     = 1'b1;
      tick();
      load = 1'b0;
      up   = 1'b1;
      repeat (10) tick();
      prev = {tens, ones};
      for (int i = 1; i <= 70; i++) begin
         step_n = (i > 50);
         tick();
         if ({tens, ones} !== prev) begin
            changes++;
            if (first_edge == 0) first_edge = i;
         end
         prev = {tens, ones};
         vectors++;
         if ({tens, ones, wrap} !== exp_word()) begin
            errors++;
            $display("FAIL autorepeat edge %0d: got %h%h wrap %b, want %h", i, tens, ones, wrap, exp_word());
         end
      end
      vectors++;
`ifdef AUTOREPEAT_EN
      if (changes != 5 || first_edge != 8 || {tens, ones} !== 8'h10) begin
         errors++;
         $display("FAIL autorepeat_steps: got %h%h after %0d steps (first at %0d), want 10 after 5 (first at 8)", tens, ones, changes, first_edge);
      end
`else
      if (changes != 1 || first_edge != 8 || {tens, ones} !== 8'h06) begin
         errors++;
         $display("FAIL autorepeat_none: got %h%h after %0d steps (first at %0d), want 06 after 1 (first at 8)", tens, ones, changes, first_edge);
      end
`endif
   endtask

   task automatic test_random();
      int left = 0;
      for (int i = 0; i < 1000; i++) begin
         if (left == 0) begin
            step_n = ~step_n;
            left   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 9));
         end
         left--;
         up       = 1'($urandom_range(0, 1));
         load     = ($urandom_range(0, 19) == 0);
         load_val = 8'($urandom);
         tick();
         vectors++;
         if ({tens, ones, wrap} !== exp_word()) begin
            errors++;
            $display("FAIL random cycle %0d: got %h%h wrap %b, want %h", i, tens, ones, wrap, exp_word());
         end
      end
      load   = 1'b0;
      step_n = 1'b1;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce();
      test_rollover();
      test_load_clamp();
      test_reset_mid();
      test_autorepeat();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/bcd_step_counter.md
Name: bcd_step_counter

Overview:
- Two-digit BCD up/down counter, driven by a debounced pushbutton.
- Sits directly upstream of the two hex-digit segment decoders that feed HEX5/HEX4. Output tens goes to the HEX5 decoder (x3..x0 = tens[3:0]); output ones goes to the HEX4 decoder.
- Turns a raw bouncing KEY press into exactly one count step, with optional parallel load from switches.

Parameters:
- DEB_CYCLES, 500000: consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz).
- RPT_DELAY, 25000000: cycles a press must be held before auto-repeat starts (AUTOREPEAT_EN only).
- RPT_PERIOD, 10000000: cycles between auto-repeat steps (AUTOREPEAT_EN only).

Ports:
- CLOCK_50  in  1  system clock; all state is on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- step_n  in  1  raw pushbutton, active-low, asynchronous to CLOCK_50.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on the cycle the step is applied.
- load  in  1  synchronous parallel load, level-sensitive.
- load_val  in  8  {tens[3:0], ones[3:0]} value to load.
- tens  out  4  BCD tens digit, 0..9.
- ones  out  4  BCD ones digit, 0..9.
- wrap  out  1  one-cycle pulse on a 99->00 or 00->99 roll-over.

Behaviour:
- Reset: tens=0, ones=0, wrap=0. Sync flops=1, debounced level=1 (released), debounce counter=0, step pulse=0, repeat timer=0. Reset asserted mid-debounce or mid-hold discards the press; after release a fresh full DEB_CYCLES period is required.
- Synchroniser: two flops on step_n; only the second flop output (s2) is used downstream.
- Debounce:
  - When s2 != deb, counter increments; when s2 == deb, counter clears.
  - When the counter reaches DEB_CYCLES-1 with s2 still != deb: deb <= s2 and counter <= 0.
  - A glitch shorter than DEB_CYCLES cycles never changes deb.
- Step pulse: registered one-cycle pulse on a deb 1->0 transition only. Release (0->1) produces no step.
- Latency: if the first rising edge sampling step_n=0 is edge 1, the count changes on edge DEB_CYCLES+4 (sync 2, debounce DEB_CYCLES, pulse 1, count 1).
- Count update on a step, up=1:
  - ones==9: ones=0 and tens increments.
  - tens==9 and ones==9: result 00, wrap=1.
- Count update on a step, up=0:
  - ones==0: ones=9 and tens decrements.
  - 00: result 99, wrap=1.
- Load:
  - Has priority over a step. While load=1, the count takes the clamped load_val every cycle and any step pulse in those cycles is discarded.
  - Each nibble >9 is clamped to 9.
  - wrap is never asserted by a load.
- wrap: 0 on every cycle except the cycle following a roll-over step. Outputs never hold a non-BCD value.

Optional Feature:
- Macro AUTOREPEAT_EN.
- Defined:
  - While deb stays 0, a repeat timer counts.
  - On reaching RPT_DELAY, one extra step pulse is issued; thereafter one pulse every RPT_PERIOD cycles.
  - The timer clears when deb returns to 1, on load, and on RESET.
  - Repeat steps obey the same up, load-priority and wrap rules.
- Undefined: exactly one step per debounced press regardless of hold time. Repeat logic and parameters are unused.

Test Plan:
(Bench overrides DEB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8.)
- Reset then clean press, up=1: step_n low from edge 1 -> count 00->01 exactly at edge 8; no further change while held or on release; wrap stays 0.
- Bounce: step_n toggles low/high every 2 cycles for 12 cycles, then stays low -> single increment only, DEB_CYCLES+4 edges after the final low.
- Roll-over: load 0x99, release load, one press with up=1 -> 00 and a one-cycle wrap=1. Then one press with up=0 -> 99 and wrap=1 again.
- Load clamp and priority: load_val=0xAF, load=1 held while a press completes -> tens=9, ones=9, no step applied, wrap=0.
- Reset mid-debounce: RESET pulsed 2 cycles after step_n falls -> count remains 00; a later press needs the full DEB_CYCLES+4 edges.
- AUTOREPEAT_EN: press held from 05, up=1 -> 06 at debounce, 07 RPT_DELAY cycles later, then +1 every 8 cycles until release; none without the macro.
